ula_mul_div: RTL and testbench

ULA_MUL_DIV -- requirements
Module: ula_mul_div

---
 rtl/ula_pkg.sv | 25 ++
 rtl/passo_mul_div.sv | 25 ++
 rtl/ula_mul_div.sv | 101 ++++++++++
 tb/tb_ula_mul_div.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: operation encodings, FSM states and operand-sign helpers
// shared by the multiply/divide unit.
package ula_pkg;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    typedef enum logic [2:0] {OCIOSO, PREPARA, CALCULA, AJUSTE, FIM} estado_t;

    function automatic logic sinal_a(op_t o);
        return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic sinal_b(op_t o);
        return o inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic e_div(op_t o);
        return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic e_resto(op_t o);
        return o inside {OP_REM, OP_REMU};
    endfunction
endpackage

// File: rtl/passo_mul_div.sv
// passo_mul_div: one iteration on magnitudes -- shift-add for multiply,
// restoring shift-subtract for divide. acc is {high, low}.
module passo_mul_div #(
    parameter int BITS = 64
) (
    input  logic              div,
    input  logic [2*BITS-1:0] acc,
    input  logic [BITS-1:0]   b,
    output logic [2*BITS-1:0] nxt
);
    logic [BITS:0]   soma;
    logic [2*BITS:0] sh;
    logic [BITS-1:0] dif;
    logic            cabe;

    always_comb begin
        soma = {1'b0, acc[2*BITS-1:BITS]} + {1'b0, acc[0] ? b : '0};
        sh   = {acc, 1'b0};
        // partial remainder stays below b, so the difference fits in BITS bits
        cabe = sh[2*BITS:BITS] >= {1'b0, b};
        dif  = sh[2*BITS-1:BITS] - b;
        nxt  = div ? (cabe ? {dif, sh[BITS-1:1], 1'b1} : sh[2*BITS-1:0])
                   : {soma, acc[BITS-1:1]};
    end
endmodule

// File: rtl/ula_mul_div.sv
// ula_mul_div: iterative RV64M-style multiply/divide unit; one step per
// cycle on magnitudes, with sign correction applied at the end.
module ula_mul_div
    import ula_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [BITS-1:0] dina,
    input  logic [BITS-1:0] dinb,
    output logic            ocupado,
    output logic            pronto,
    output logic [BITS-1:0] dout
);
    localparam int CW = $clog2(BITS) + 1;

    estado_t           state, next;
    op_t               op_r;
    logic [BITS-1:0]   a_r, b_r, mb, ma, val_esp, div_val, res;
    logic [2*BITS-1:0] acc, acc_nxt, p;
    logic [CW-1:0]     cnt;
    logic              neg, sa, sb, especial;

    passo_mul_div #(.BITS(BITS)) u_passo (
        .div(e_div(op_r)),
        .acc(acc),
        .b(mb),
        .nxt(acc_nxt)
    );

    always_comb begin
        sa       = sinal_a(op_r) & a_r[BITS-1];
        sb       = sinal_b(op_r) & b_r[BITS-1];
        ma       = sa ? -a_r : a_r;
        especial = e_div(op_r) && (b_r == '0 ||
                   (sinal_b(op_r) && a_r == {1'b1, {(BITS-1){1'b0}}} && &b_r));
        val_esp  = (b_r == '0) ? (e_resto(op_r) ? a_r : '1)
                               : (e_resto(op_r) ? '0 : a_r);
        p        = neg ? -acc : acc;
        div_val  = e_resto(op_r) ? acc[2*BITS-1:BITS] : acc[BITS-1:0];
        res      = e_div(op_r) ? (neg ? -div_val : div_val)
                               : (op_r == OP_MUL ? p[BITS-1:0] : p[2*BITS-1:BITS]);
        ocupado  = state != OCIOSO;
        pronto   = state == FIM;
    end

    always_comb begin
        next = state;
        case (state)
            OCIOSO:  next = start ? PREPARA : OCIOSO;
            PREPARA: next = especial ? FIM : CALCULA;
            CALCULA: next = (cnt == CW'(BITS - 1)) ? AJUSTE : CALCULA;
            AJUSTE:  next = FIM;
            default: next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= OCIOSO;
        else
            state <= next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            dout <= '0;
            acc  <= '0;
            mb   <= '0;
            neg  <= 1'b0;
            op_r <= OP_MUL;
            a_r  <= '0;
            b_r  <= '0;
        end else begin
            case (state)
                OCIOSO: if (start) begin
                    op_r <= op_t'(op);
                    a_r  <= dina;
                    b_r  <= dinb;
                end
                PREPARA: begin
                    mb  <= sb ? -b_r : b_r;
                    acc <= {{BITS{1'b0}}, ma};
                    neg <= e_resto(op_r) ? sa : sa ^ sb;
                    cnt <= '0;
                    if (especial) dout <= val_esp;
                end
                CALCULA: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                end
                AJUSTE: dout <= res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_mul_div.sv
// tb_ula_mul_div: directed and random checks of ula_mul_div against an
// arithmetic reference model.
module tb_ula_mul_div;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 0, reset = 1, start = 0;
    logic [2:0]  op = 0;
    logic [63:0] dina = 0, dinb = 0, dout;
    logic        ocupado, pronto;
    int          checks = 0, failures = 0;

    ula_mul_div #(.BITS(64)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .dina(dina), .dinb(dinb), .ocupado(ocupado), .pronto(pronto), .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] modelo(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pu;
        logic signed [127:0] ps;
        case (o)
            3'd0: return a * b;
            3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return ps[127:64]; end
            3'd2: begin pu = {{64{a[63]}}, a} * {64'b0, b}; return pu[127:64]; end
            3'd3: begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
            3'd4: return (b == 0) ? '1 : (a == MINV && b == '1) ? a : 64'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: return (b == 0) ? a : (a == MINV && b == '1) ? 64'd0 : 64'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latencia(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o >= 3'd4 && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == MINV && b == '1))) return 2;
        return 67;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // start accepted at the posedge ending cycle 0; samples taken #1 after each edge
    task automatic go(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input string tag);
        int cyc;
        @(negedge clk);
        op = o; dina = a; dinb = b; start = 1;
        @(posedge clk); #1 start = 0; cyc = 1;
        chk({tag, " busy"}, {63'b0, ocupado}, 64'd1);
        while (!pronto && cyc < 150) begin
            @(posedge clk); #1 cyc++;
        end
        chk({tag, " lat"}, 64'(cyc), 64'(latencia(o, a, b)));
        chk({tag, " dout"}, dout, modelo(o, a, b));
        @(posedge clk); #1;
        chk({tag, " idle"}, {62'b0, pronto, ocupado}, 64'd0);
    endtask

    initial begin
        int cyc, r;
        logic [2:0]  o;
        logic [63:0] a, b;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", {pronto, ocupado, dout}, 66'd0);
        reset = 0;

        go(3'd0, 64'd7, 64'd6, "mul 7*6");
        go(3'd4, -64'sd7, 64'd2, "div -7/2");
        go(3'd6, -64'sd7, 64'd2, "rem -7/2");
        go(3'd1, '1, 64'd2, "mulh -1*2");
        go(3'd3, '1, 64'd2, "mulhu ff*2");
        go(3'd5, 64'd5, 64'd0, "divu 5/0");
        go(3'd7, 64'd5, 64'd0, "remu 5/0");
        go(3'd4, MINV, '1, "div ovf");
        go(3'd6, MINV, '1, "rem ovf");
        go(3'd2, '1, '1, "mulhsu -1*ff");

        // start during a running MUL must be ignored
        @(negedge clk);
        op = 3'd0; dina = 64'd7; dinb = 64'd6; start = 1;
        @(posedge clk); #1 start = 0; cyc = 1;
        while (!pronto && cyc < 150) begin
            if (cyc == 10) begin op = 3'd0; dina = 64'd100; dinb = 64'd100; start = 1; end
            if (cyc == 11) start = 0;
            @(posedge clk); #1 cyc++;
        end
        start = 0;
        chk("ignore lat", 64'(cyc), 64'd67);
        chk("ignore dout", dout, 64'd42);
        @(posedge clk); #1;
        chk("ignore idle", {63'b0, ocupado}, 64'd0);

        // reset aborts a running DIV
        @(negedge clk);
        op = 3'd4; dina = 64'd1000; dinb = 64'd7; start = 1;
        @(posedge clk); #1 start = 0; cyc = 1;
        while (cyc < 20) begin @(posedge clk); #1 cyc++; end
        reset = 1;
        @(posedge clk); #1 reset = 0;
        chk("abort state", {pronto, ocupado, dout}, 66'd0);
        go(3'd0, 64'd3, 64'd3, "mul 3*3");

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r == 0) b = 0;
            if (r == 1) b = '1;
            if (r == 2) b = 64'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) a = MINV;
            go(o, a, b, $sformatf("rand%0d op%0d", i, o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
